// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. It takes the execute result and retires a
// one-cycle writeback record. Memory ops run a req/ack transaction with data
// memory: big-endian byte lanes, sign/zero extension, alignment and timeout.
//
// Handshake: a transfer happens on a rising clock edge where in_valid and
// in_ready are both 1. in_ready depends only on state and reset, never on
// in_valid. mem_req stays high, with address, data, enables and direction
// stable, until the first edge where mem_ack = 1. mem_ack has no effect while
// mem_req is 0.
//
// Byte lanes are numbered big-endian. Lane 0 is the lowest address and holds
// bits [31:24] of a word. The lane number is in_alu[1:0].
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rt,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_dest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        err_align,
  output logic        err_timeout,
  output logic        state_dbg
);

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  // wait_cnt holds the number of WAIT cycles already spent without an ack.
  // The cycle where it equals LIMIT is the MAX_WAIT-th WAIT cycle, so the
  // timeout takes effect on that cycle's edge.
  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  dest_q;
  logic [31:0] pc_q;

  logic        accept;
  logic        in_is_load, in_is_store, in_is_mem, in_misalign;
  logic        start_txn, done_ack, done_to;
  logic        q_is_load;
  logic [7:0]  rbyte;
  logic [31:0] load_val;
  logic [3:0]  sb_be;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  // Decode the incoming op and check alignment.
  always_comb begin
    in_is_load  = (in_op == OP_LW) || (in_op == OP_LB) || (in_op == OP_LBU);
    in_is_store = (in_op == OP_SW) || (in_op == OP_SB);
    in_is_mem   = in_is_load || in_is_store;
    in_misalign = ((in_op == OP_LW) || (in_op == OP_SW)) && (in_alu[1:0] != 2'b00);
    sb_be       = 4'b1000;
    case (in_alu[1:0])
      2'd0:    sb_be = 4'b1000;
      2'd1:    sb_be = 4'b0100;
      2'd2:    sb_be = 4'b0010;
      default: sb_be = 4'b0001;
    endcase
  end

  // Select the byte lane from the returned data and extend it for the load type.
  always_comb begin
    q_is_load = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU);
    rbyte     = mem_rdata[31:24];
    case (lane_q)
      2'd0:    rbyte = mem_rdata[31:24];
      2'd1:    rbyte = mem_rdata[23:16];
      2'd2:    rbyte = mem_rdata[15:8];
      default: rbyte = mem_rdata[7:0];
    endcase
    load_val = '0;
    case (op_q)
      OP_LW:   load_val = mem_rdata;
      OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_val = {24'b0, rbyte};
      default: load_val = '0;
    endcase
  end

  // Next-state logic and transaction events.
  always_comb begin
    state_nxt = state;
    start_txn = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && in_is_mem && !in_misalign) begin
          start_txn = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          done_ack  = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == LIMIT) begin
          done_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Memory request, transaction context, wait counter and retire record.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      dest_q      <= '0;
      pc_q        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_dest     <= '0;
      wb_data     <= '0;
      wb_pc       <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;

      if (start_txn) begin
        mem_req  <= 1'b1;
        mem_we   <= in_is_store;
        mem_addr <= {in_alu[31:2], 2'b00};
        if (in_op == OP_SB) begin
          mem_be    <= sb_be;
          mem_wdata <= {4{in_rt[7:0]}};
        end else begin
          mem_be    <= 4'b1111;
          mem_wdata <= (in_op == OP_SW) ? in_rt : 32'h0;
        end
        op_q     <= in_op;
        lane_q   <= in_alu[1:0];
        dest_q   <= in_dest;
        pc_q     <= in_pc;
        wait_cnt <= '0;
      end else if (done_ack || done_to) begin
        mem_req  <= 1'b0;
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (accept && !in_is_mem) begin
        wb_valid <= 1'b1;
        wb_we    <= (in_dest != 5'd0);
        wb_data  <= in_alu;
        wb_dest  <= in_dest;
        wb_pc    <= in_pc;
      end else if (accept && in_misalign) begin
        wb_valid  <= 1'b1;
        wb_we     <= 1'b0;
        wb_data   <= '0;
        wb_dest   <= in_dest;
        wb_pc     <= in_pc;
        err_align <= 1'b1;
      end else if (done_ack) begin
        wb_valid <= 1'b1;
        wb_we    <= q_is_load && (dest_q != 5'd0);
        wb_data  <= q_is_load ? load_val : 32'h0;
        wb_dest  <= dest_q;
        wb_pc    <= pc_q;
      end else if (done_to) begin
        wb_valid    <= 1'b1;
        wb_we       <= 1'b0;
        wb_data     <= '0;
        wb_dest     <= dest_q;
        wb_pc       <= pc_q;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage. Directed steps come first, then random ops.
// A reference model derives each expected retire from the op semantics.
module tb_mem_access_stage;

  localparam int MW = 4;
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_LB   = 3'd2;
  localparam logic [2:0] OP_LBU  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_SB   = 3'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_alu, in_rt;
  logic [2:0]  in_op;
  logic [4:0]  in_dest;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data, wb_pc;
  logic        err_align, err_timeout;
  logic        state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  last_dest;
  logic [31:0] last_data, last_pc;

  // Clock and DUT
  always #5 clock = ~clock;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_rt(in_rt), .in_op(in_op), .in_dest(in_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_pc(wb_pc), .err_align(err_align), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input int lane);
    return 8'(w >> (8 * (3 - lane)));
  endfunction

  // Every output must read zero while reset is applied.
  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 0);
    chk({tag, ".mem_req"}, {31'b0, mem_req}, 0);
    chk({tag, ".mem_we"}, {31'b0, mem_we}, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_be"}, {28'b0, mem_be}, 0);
    chk({tag, ".wb_valid"}, {31'b0, wb_valid}, 0);
    chk({tag, ".wb_we"}, {31'b0, wb_we}, 0);
    chk({tag, ".wb_dest"}, {27'b0, wb_dest}, 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".wb_pc"}, wb_pc, 0);
    chk({tag, ".err"}, {30'b0, err_align, err_timeout}, 0);
  endtask

  // Issue one op at the current negedge. k is the WAIT cycle (1-based) that
  // carries the ack; k outside 1..MW means memory never acknowledges.
  // The task returns at the negedge of the retire cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [31:0] rdata, input logic [4:0] dest, input int k);
    logic [31:0] pc, exp_data, exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic [7:0]  b;
    logic        is_load, is_store, is_mem, mis, exp_to, exp_we;
    int          lane;
    pc       = $urandom;
    lane     = int'(alu & 32'd3);
    is_load  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    is_store = (op == OP_SW) || (op == OP_SB);
    is_mem   = is_load || is_store;
    mis      = ((op == OP_LW) || (op == OP_SW)) && (lane != 0);
    exp_to   = is_mem && !mis && (k < 1 || k > MW);
    b        = pick_byte(rdata, lane);
    exp_addr = alu & ~32'd3;
    exp_be   = (op == OP_SB) ? 4'(8 >> lane) : 4'hF;
    exp_wd   = (op == OP_SW) ? rt : (op == OP_SB) ? ((rt & 32'hFF) * 32'h0101_0101) : 32'h0;
    if (!is_mem) begin
      exp_data = alu;
      exp_we   = (dest != 0);
    end else if (mis || exp_to || is_store) begin
      exp_data = 0;
      exp_we   = 0;
    end else begin
      exp_we = (dest != 0);
      if (op == OP_LW)      exp_data = rdata;
      else if (op == OP_LB) exp_data = (b >= 8'd128) ? (32'hFFFF_FF00 | {24'b0, b}) : {24'b0, b};
      else                  exp_data = {24'b0, b};
    end
    exp_q.push_back(exp_data);

    chk("issue.in_ready", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_alu   = alu;
    in_rt    = rt;
    in_dest  = dest;
    in_pc    = pc;
    @(negedge clock);
    in_valid = 1'b0;
    in_op    = $urandom;
    in_alu   = $urandom;

    if (is_mem && !mis) begin
      for (int j = 1; j <= MW; j++) begin
        chk("wait.mem_req", {31'b0, mem_req}, 1);
        chk("wait.in_ready", {31'b0, in_ready}, 0);
        chk("wait.wb_valid", {31'b0, wb_valid}, 0);
        chk("wait.mem_we", {31'b0, mem_we}, {31'b0, is_store});
        chk("wait.mem_addr", mem_addr, exp_addr);
        chk("wait.mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        chk("wait.mem_wdata", mem_wdata, exp_wd);
        if (j == k) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        @(negedge clock);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (j == k) break;
      end
    end

    chk("ret.wb_valid", {31'b0, wb_valid}, 1);
    chk("ret.wb_we", {31'b0, wb_we}, {31'b0, exp_we});
    chk("ret.wb_dest", {27'b0, wb_dest}, {27'b0, dest});
    chk("ret.wb_pc", wb_pc, pc);
    chk("ret.wb_data", wb_data, exp_q.pop_front());
    chk("ret.err_align", {31'b0, err_align}, {31'b0, mis});
    chk("ret.err_timeout", {31'b0, err_timeout}, {31'b0, exp_to});
    chk("ret.mem_req", {31'b0, mem_req}, 0);
    chk("ret.in_ready", {31'b0, in_ready}, 1);
    last_dest = dest;
    last_data = exp_data;
    last_pc   = pc;
  endtask

  // One idle cycle: the pulses must be gone and the record must be held.
  task automatic idle_check();
    @(negedge clock);
    chk("idle.wb_valid", {31'b0, wb_valid}, 0);
    chk("idle.err", {30'b0, err_align, err_timeout}, 0);
    chk("idle.wb_dest", {27'b0, wb_dest}, {27'b0, last_dest});
    chk("idle.wb_data", wb_data, last_data);
    chk("idle.wb_pc", wb_pc, last_pc);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ralu;
    int          rk;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = 0;
    in_alu    = 0;
    in_rt     = 0;
    in_op     = 0;
    in_dest   = 0;
    mem_rdata = 0;
    mem_ack   = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("post_reset.in_ready", {31'b0, in_ready}, 1);

    // Non-memory ops: dest 5 writes, dest 0 does not. The two are issued back to back.
    run_op(OP_NONE, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0);
    run_op(OP_NONE, 32'h0000_5678, 32'h0, 32'h0, 5'd0, 0);
    idle_check();

    // Byte loads with the ack on WAIT cycle 3.
    run_op(OP_LB,  32'h0000_0103, 32'h0, 32'h1122_3384, 5'd7, 3);
    run_op(OP_LBU, 32'h0000_0103, 32'h0, 32'h1122_3384, 5'd8, 3);

    // Byte store to lane 1.
    run_op(OP_SB, 32'h0000_0201, 32'hDEAD_BEA5, 32'h0, 5'd9, 2);

    // Misaligned word load issues no request and pulses err_align.
    run_op(OP_LW, 32'h0000_0102, 32'h0, 32'h0, 5'd3, 1);
    idle_check();

    // A word load with no ack times out. Then an ack on the last WAIT cycle wins.
    run_op(OP_LW, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 5'd4, 0);
    idle_check();
    run_op(OP_LW, 32'h0000_0404, 32'h0, 32'h1357_9BDF, 5'd4, MW);

    // An ack while no request is pending has no effect.
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("stray_ack.wb_valid", {31'b0, wb_valid}, 0);
    chk("stray_ack.mem_req", {31'b0, mem_req}, 0);

    // Reset in the middle of WAIT: the request drops and nothing retires.
    in_valid = 1'b1;
    in_op    = OP_LW;
    in_alu   = 32'h0000_0800;
    in_dest  = 5'd6;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("midwait.mem_req", {31'b0, mem_req}, 1);
    reset = 1'b1;
    #1;
    chk("midwait.in_ready", {31'b0, in_ready}, 0);
    @(negedge clock);
    chk_all_zero("midwait_reset");
    reset = 1'b0;
    #1;
    chk("after_reset.in_ready", {31'b0, in_ready}, 1);
    run_op(OP_LW, 32'h0000_0800, 32'h0, 32'h2468_ACE0, 5'd6, 1);

    // Random ops checked against the reference model.
    for (int i = 0; i < 80; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ralu = $urandom;
      rk   = $urandom_range(1, MW + 1);
      run_op(rop, ralu, $urandom, $urandom, 5'($urandom_range(0, 31)), rk);
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
